// File: rtl/cpri_rx_align_ctrl.sv
// CPRI receive lane-alignment controller: waits for all lane buffers, then issues
// BURST_LEN-beat broadcast reads. Optional counters are built when CPRI_ALIGN_STATS_EN is defined.
module cpri_rx_align_ctrl #(
    parameter int LANE      = 8,
    parameter int BURST_LEN = 96,
    parameter int TIMEOUT   = 1024
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [1:0]      i_dr_mode,
    input  logic [LANE-1:0] i_buf_vld,
    input  logic            i_tready,
    input  logic            i_hdr_vld,
    input  logic [6:0]      i_slot_idx,
    input  logic [3:0]      i_symb_idx,
    output logic            o_rd_en,
    output logic [6:0]      o_rd_addr,
    output logic            o_rd_last,
    output logic            o_flush,
    output logic            o_align_err,
    output logic [LANE-1:0] o_err_lane,
    output logic            o_resort_req,
    output logic [31:0]     o_burst_cnt,
    output logic [15:0]     o_err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ, ST_FLUSH} state_e;

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [6:0]      ADDR_MAX = 7'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [6:0]        addr_q, addr_d;
    logic              align_err_q, align_err_d;
    logic [LANE-1:0]   err_lane_q, err_lane_d;
    logic              resort_q, resort_d;
    logic              mode0_done_q, mode0_done_d;
    logic              all_vld, any_vld, rd_en, timeout_evt, burst_done;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        addr_d       = addr_q;
        align_err_d  = align_err_q;
        err_lane_d   = err_lane_q;
        timeout_evt  = 1'b0;
        burst_done   = 1'b0;
        all_vld      = &i_buf_vld;
        any_vld      = |i_buf_vld;
        rd_en        = (state_q == ST_READ) & i_tready & all_vld;

        case (state_q)
            ST_IDLE: begin
                if (all_vld) begin
                    state_d     = ST_READ;
                    wait_cnt_d  = '0;
                    stall_cnt_d = '0;
                end else if (any_vld) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // Alignment is checked before the timeout so a late lane still wins.
                if (all_vld) begin
                    state_d     = ST_READ;
                    wait_cnt_d  = '0;
                    stall_cnt_d = '0;
                end else if (wait_cnt_q == CNT_MAX) begin
                    timeout_evt = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    stall_cnt_d = '0;
                    if (addr_q == ADDR_MAX) begin
                        addr_d     = '0;
                        state_d    = ST_IDLE;
                        burst_done = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (stall_cnt_q == CNT_MAX) begin
                    timeout_evt = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase

        if (timeout_evt) begin
            state_d     = ST_FLUSH;
            addr_d      = '0;
            align_err_d = 1'b1;
            if (!align_err_q) err_lane_d = ~i_buf_vld;
        end
    end

    // Re-sort decision is registered, so the request lands one cycle after the header.
    always_comb begin
        resort_d     = 1'b0;
        mode0_done_d = mode0_done_q | i_hdr_vld;
        if (i_hdr_vld) begin
            case (i_dr_mode)
                2'd0:    resort_d = ~mode0_done_q;
                2'd1:    resort_d = (i_slot_idx == 7'd0) && (i_symb_idx == 4'd0);
                2'd2:    resort_d = (i_symb_idx == 4'd0);
                default: resort_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            addr_q       <= '0;
            align_err_q  <= 1'b0;
            err_lane_q   <= '0;
            resort_q     <= 1'b0;
            mode0_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            addr_q       <= addr_d;
            align_err_q  <= align_err_d;
            err_lane_q   <= err_lane_d;
            resort_q     <= resort_d;
            mode0_done_q <= mode0_done_d;
        end
    end

`ifdef CPRI_ALIGN_STATS_EN
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (burst_done && (burst_cnt_q != '1)) burst_cnt_d = burst_cnt_q + 1'b1;
        if (timeout_evt && (err_cnt_q != '1))  err_cnt_d   = err_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_burst_cnt = burst_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_burst_cnt = '0;
    assign o_err_cnt   = '0;
`endif

    assign o_rd_en      = rd_en;
    assign o_rd_addr    = addr_q;
    assign o_rd_last    = rd_en & (addr_q == ADDR_MAX);
    assign o_flush      = (state_q == ST_FLUSH);
    assign o_align_err  = align_err_q;
    assign o_err_lane   = err_lane_q;
    assign o_resort_req = resort_q;

endmodule

// File: tb/tb_cpri_rx_align_ctrl.sv
// Randomized and directed bench for cpri_rx_align_ctrl; counter expectations follow CPRI_ALIGN_STATS_EN.
module tb_cpri_rx_align_ctrl;

    localparam int LANE = 8;
    localparam int BL   = 96;
    localparam int TO   = 1024;
`ifdef CPRI_ALIGN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic [1:0]      i_dr_mode;
    logic [LANE-1:0] i_buf_vld;
    logic            i_tready;
    logic            i_hdr_vld;
    logic [6:0]      i_slot_idx;
    logic [3:0]      i_symb_idx;
    logic            o_rd_en;
    logic [6:0]      o_rd_addr;
    logic            o_rd_last;
    logic            o_flush;
    logic            o_align_err;
    logic [LANE-1:0] o_err_lane;
    logic            o_resort_req;
    logic [31:0]     o_burst_cnt;
    logic [15:0]     o_err_cnt;

    int total = 0;
    int bad   = 0;

    cpri_rx_align_ctrl #(.LANE(LANE), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_dr_mode(i_dr_mode), .i_buf_vld(i_buf_vld),
        .i_tready(i_tready), .i_hdr_vld(i_hdr_vld), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_rd_last(o_rd_last), .o_flush(o_flush),
        .o_align_err(o_align_err), .o_err_lane(o_err_lane), .o_resort_req(o_resort_req),
        .o_burst_cnt(o_burst_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0; i_buf_vld = '0; i_tready = 1'b1; i_hdr_vld = 1'b0;
        i_dr_mode = 2'd0; i_slot_idx = '0; i_symb_idx = '0;
        step(); step();
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (o_rd_en !== 1'b0)      begin bad++; $display("FAIL rst_rd_en got=%0h exp=0", o_rd_en); end
        total++; if (o_rd_addr !== 7'd0)    begin bad++; $display("FAIL rst_addr got=%0d exp=0", o_rd_addr); end
        total++; if (o_rd_last !== 1'b0)    begin bad++; $display("FAIL rst_last got=%0h exp=0", o_rd_last); end
        total++; if (o_flush !== 1'b0)      begin bad++; $display("FAIL rst_flush got=%0h exp=0", o_flush); end
        total++; if (o_align_err !== 1'b0)  begin bad++; $display("FAIL rst_err got=%0h exp=0", o_align_err); end
        total++; if (o_err_lane !== 8'h00)  begin bad++; $display("FAIL rst_err_lane got=%0h exp=0", o_err_lane); end
        total++; if (o_resort_req !== 1'b0) begin bad++; $display("FAIL rst_resort got=%0h exp=0", o_resort_req); end
        total++; if (o_burst_cnt !== 32'd0) begin bad++; $display("FAIL rst_burst_cnt got=%0d exp=0", o_burst_cnt); end
        total++; if (o_err_cnt !== 16'd0)   begin bad++; $display("FAIL rst_err_cnt got=%0d exp=0", o_err_cnt); end
    endtask

    task automatic test_full_burst();
        do_reset();
        i_buf_vld = 8'hFF; i_tready = 1'b1;
        step();
        for (int i = 0; i < BL; i++) begin
            #1;
            total++; if (o_rd_en !== 1'b1 || o_rd_addr !== 7'(i) || o_rd_last !== (i == BL - 1))
                begin bad++; $display("FAIL burst_beat%0d got en=%0h addr=%0d last=%0h exp en=1 addr=%0d last=%0h",
                                      i, o_rd_en, o_rd_addr, o_rd_last, i, (i == BL - 1)); end
            step();
        end
        i_buf_vld = 8'h00;
        #1;
        total++; if (o_rd_en !== 1'b0 || o_rd_addr !== 7'd0)
            begin bad++; $display("FAIL burst_end got en=%0h addr=%0d exp en=0 addr=0", o_rd_en, o_rd_addr); end
        total++; if (o_burst_cnt !== (STATS ? 32'd1 : 32'd0))
            begin bad++; $display("FAIL burst_cnt got=%0d exp=%0d", o_burst_cnt, STATS ? 1 : 0); end
        total++; if (o_align_err !== 1'b0) begin bad++; $display("FAIL burst_no_err got=%0h exp=0", o_align_err); end
    endtask

    task automatic test_lane_timeout();
        int n;
        do_reset();
        i_buf_vld = 8'h7F;
        n = 0;
        #1;
        while (o_flush !== 1'b1 && n < 2000) begin
            step(); n++; #1;
        end
        // One IDLE edge, then TIMEOUT cycles in WAIT before FLUSH is visible.
        total++; if (n !== TO + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO + 1); end
        total++; if (o_align_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0h exp=1", o_align_err); end
        total++; if (o_err_lane !== 8'h80) begin bad++; $display("FAIL timeout_err_lane got=%0h exp=80", o_err_lane); end
        total++; if (o_err_cnt !== (STATS ? 16'd1 : 16'd0))
            begin bad++; $display("FAIL timeout_err_cnt got=%0d exp=%0d", o_err_cnt, STATS ? 1 : 0); end
        total++; if (o_rd_addr !== 7'd0) begin bad++; $display("FAIL flush_addr got=%0d exp=0", o_rd_addr); end
        i_buf_vld = 8'h00;
        step(); #1;
        total++; if (o_flush !== 1'b0) begin bad++; $display("FAIL flush_one_cycle got=%0h exp=0", o_flush); end
        total++; if (o_align_err !== 1'b1 || o_err_lane !== 8'h80)
            begin bad++; $display("FAIL err_sticky got err=%0h lane=%0h exp err=1 lane=80", o_align_err, o_err_lane); end
    endtask

    task automatic test_tready_stall();
        int beats;
        do_reset();
        i_buf_vld = 8'hFF; i_tready = 1'b1;
        step();
        for (int i = 0; i < 40; i++) step();
        i_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if (o_rd_en !== 1'b0 || o_rd_addr !== 7'd40)
                begin bad++; $display("FAIL stall%0d got en=%0h addr=%0d exp en=0 addr=40", i, o_rd_en, o_rd_addr); end
            step();
        end
        i_tready = 1'b1;
        #1;
        total++; if (o_rd_en !== 1'b1 || o_rd_addr !== 7'd40)
            begin bad++; $display("FAIL stall_resume got en=%0h addr=%0d exp en=1 addr=40", o_rd_en, o_rd_addr); end
        step(); #1;
        total++; if (o_rd_addr !== 7'd41) begin bad++; $display("FAIL stall_next got=%0d exp=41", o_rd_addr); end
        beats = 0;
        for (int i = 0; i < 200 && o_rd_en === 1'b1; i++) begin beats++; step(); #1; end
        total++; if (beats !== BL - 41) begin bad++; $display("FAIL stall_rest_beats got=%0d exp=%0d", beats, BL - 41); end
        total++; if (o_align_err !== 1'b0) begin bad++; $display("FAIL stall_no_err got=%0h exp=0", o_align_err); end
        i_buf_vld = 8'h00;
    endtask

    task automatic send_hdr(input logic [1:0] mode, input logic [6:0] slot, input logic [3:0] symb, output logic got);
        i_dr_mode = mode; i_slot_idx = slot; i_symb_idx = symb; i_hdr_vld = 1'b1;
        step();
        i_hdr_vld = 1'b0;
        #1;
        got = o_resort_req;
        step();
    endtask

    task automatic test_resort();
        logic got;
        logic exp_q[$];
        do_reset();
        exp_q = '{1'b0, 1'b1, 1'b0};
        send_hdr(2'd1, 7'd3, 4'd0, got);
        total++; if (got !== exp_q[0]) begin bad++; $display("FAIL m1_hdr0 got=%0h exp=%0h", got, exp_q[0]); end
        send_hdr(2'd1, 7'd0, 4'd0, got);
        total++; if (got !== exp_q[1]) begin bad++; $display("FAIL m1_hdr1 got=%0h exp=%0h", got, exp_q[1]); end
        #1;
        total++; if (o_resort_req !== 1'b0) begin bad++; $display("FAIL m1_pulse_width got=%0h exp=0", o_resort_req); end
        send_hdr(2'd1, 7'd0, 4'd5, got);
        total++; if (got !== exp_q[2]) begin bad++; $display("FAIL m1_hdr2 got=%0h exp=%0h", got, exp_q[2]); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_hdr(2'd0, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), got);
            total++; if (got !== (i == 0)) begin bad++; $display("FAIL m0_hdr%0d got=%0h exp=%0h", i, got, (i == 0)); end
        end
    endtask

    // Header stream with random modes and spacing against a rule-based model.
    task automatic test_resort_random();
        bit seen, exp_next;
        logic [1:0] m; logic [6:0] sl; logic [3:0] sy;
        do_reset();
        seen = 1'b0; exp_next = 1'b0;
        for (int i = 0; i < 400; i++) begin
            m  = 2'($urandom_range(0, 3));
            sl = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            sy = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            i_dr_mode = m; i_slot_idx = sl; i_symb_idx = sy;
            i_hdr_vld = ($urandom_range(0, 1) == 1);
            #1;
            total++; if (o_resort_req !== exp_next)
                begin bad++; $display("FAIL resort_rand%0d got=%0h exp=%0h", i, o_resort_req, exp_next); end
            exp_next = 1'b0;
            if (i_hdr_vld) begin
                if (m == 2'd0)      exp_next = !seen;
                else if (m == 2'd1) exp_next = (sl == 0) && (sy == 0);
                else if (m == 2'd2) exp_next = (sy == 0);
                seen = 1'b1;
            end
            step();
        end
        i_hdr_vld = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        i_buf_vld = 8'hFF; i_tready = 1'b1;
        step();
        for (int i = 0; i < 50; i++) step();
        #1;
        total++; if (o_rd_addr !== 7'd50) begin bad++; $display("FAIL midrst_pre got=%0d exp=50", o_rd_addr); end
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        #1;
        total++; if (o_rd_en !== 1'b0 || o_rd_addr !== 7'd0)
            begin bad++; $display("FAIL midrst_idle got en=%0h addr=%0d exp en=0 addr=0", o_rd_en, o_rd_addr); end
        step(); #1;
        total++; if (o_rd_en !== 1'b1 || o_rd_addr !== 7'd0)
            begin bad++; $display("FAIL midrst_restart got en=%0h addr=%0d exp en=1 addr=0", o_rd_en, o_rd_addr); end
        i_buf_vld = 8'h00;
    endtask

    task automatic test_skew_boundary();
        int flushes;
        do_reset();
        i_buf_vld = 8'h7F;
        flushes = 0;
        for (int i = 0; i < TO; i++) begin
            #1; if (o_flush === 1'b1) flushes++;
            step();
        end
        i_buf_vld = 8'hFF;
        #1; if (o_flush === 1'b1) flushes++;
        step(); #1;
        total++; if (flushes !== 0) begin bad++; $display("FAIL skew_flush got=%0d exp=0", flushes); end
        total++; if (o_rd_en !== 1'b1 || o_rd_addr !== 7'd0)
            begin bad++; $display("FAIL skew_read got en=%0h addr=%0d exp en=1 addr=0", o_rd_en, o_rd_addr); end
        total++; if (o_align_err !== 1'b0) begin bad++; $display("FAIL skew_no_err got=%0h exp=0", o_align_err); end
        i_buf_vld = 8'h00;
    endtask

    // Random lane/ready traffic. Model: a burst starts once all lanes are up, delivers
    // beats on ready cycles, and closes with one idle cycle; partial lanes just wait.
    task automatic test_random_traffic();
        bit in_burst, waiting, allv, exp_en;
        int beat, bursts;
        do_reset();
        in_burst = 0; waiting = 0; beat = 0; bursts = 0;
        for (int c = 0; c < 4000; c++) begin
            i_buf_vld = ($urandom_range(0, 9) < 8) ? 8'hFF : 8'($urandom);
            i_tready  = ($urandom_range(0, 9) < 7);
            allv   = (i_buf_vld == 8'hFF);
            exp_en = in_burst && i_tready && allv;
            #1;
            total++; if (o_rd_en !== exp_en || o_rd_addr !== 7'(beat) || o_rd_last !== (exp_en && beat == BL - 1))
                begin bad++; $display("FAIL rand_c%0d got en=%0h addr=%0d last=%0h exp en=%0h addr=%0d last=%0h",
                                      c, o_rd_en, o_rd_addr, o_rd_last, exp_en, beat, exp_en && beat == BL - 1); end
            if (in_burst) begin
                if (exp_en) begin
                    beat = beat + 1;
                    if (beat == BL) begin beat = 0; in_burst = 0; bursts++; end
                end
            end else if (allv) begin
                in_burst = 1; waiting = 0;
            end else if (i_buf_vld != 0) begin
                waiting = 1;
            end
            step();
        end
        i_buf_vld = 8'h00;
        #1;
        total++; if (o_burst_cnt !== (STATS ? 32'(bursts) : 32'd0))
            begin bad++; $display("FAIL rand_bursts got=%0d exp=%0d", o_burst_cnt, STATS ? bursts : 0); end
        total++; if (o_align_err !== 1'b0) begin bad++; $display("FAIL rand_no_err got=%0h exp=0", o_align_err); end
    endtask

    initial begin
        i_reset_n = 1'b0; i_dr_mode = 2'd0; i_buf_vld = '0; i_tready = 1'b0;
        i_hdr_vld = 1'b0; i_slot_idx = '0; i_symb_idx = '0;
        test_reset();
        test_full_burst();
        test_lane_timeout();
        test_tready_stall();
        test_resort();
        test_resort_random();
        test_reset_mid_burst();
        test_skew_boundary();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
